// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants and FSM state encoding shared by the ALU arbiter
package alu_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;
  typedef enum logic [2:0] {
    IDLE, START, LOAD_A, LOAD_B, LOAD_C, WAIT, RES_HI, DONE
  } state_t;
endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: byte-serial link between the arbiter and the shared ALU
interface alu_arbiter_if;
  logic [1:0] alu_op;
  logic [7:0] alu_in;
  logic       alu_begin;
  logic [7:0] alu_out;
  logic       alu_end;
  modport master (output alu_op, alu_in, alu_begin, input alu_out, alu_end);
  modport slave (input alu_op, alu_in, alu_begin, output alu_out, alu_end);
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant; a tie goes to the side not served last
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);
  logic last_q, last_d;
  always_comb begin
    grant = req == 2'b11 ? (last_q ? 2'b01 : 2'b10) : req;
    last_d = advance && |grant ? grant[1] : last_q;
  end
  // last_q resets to side 1 so that side 0 wins the first tie
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_q <= 1'b1;
    else last_q <= last_d;
  end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one byte-serial ALU between two requesters with timeout abort
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int TW      = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [1:0]  op0,
  input  logic [1:0]  op1,
  input  logic [7:0]  a0,
  input  logic [7:0]  b0,
  input  logic [7:0]  c0,
  input  logic [7:0]  a1,
  input  logic [7:0]  b1,
  input  logic [7:0]  c1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] res0,
  output logic [15:0] res1,
  output logic        err0,
  output logic        err1,
  output logic        busy,
  alu_arbiter_if.master alu
);
  state_t          state_q, state_d;
  logic            side_q, side_d, err_q, err_d;
  logic [1:0]      op_q, op_d;
  logic [7:0]      a_q, a_d, b_q, b_d, c_q, c_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [15:0]     res0_q, res0_d, res1_q, res1_d, res_cur, res_nxt;
  logic [1:0]      grant;
  logic            timeout;

  rr_arb2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     ({req1, req0}),
    .advance (state_q == IDLE),
    .grant   (grant)
  );

  always_comb begin
    state_d = state_q;
    side_d  = side_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    res0_d  = res0_q;
    res1_d  = res1_q;
    res_cur = side_q ? res1_q : res0_q;
    res_nxt = res_cur;
    timeout = cnt_q == TW'(TIMEOUT - 1);
    case (state_q)
      IDLE: if (|grant) begin
        side_d  = grant[1];
        op_d    = grant[1] ? op1 : op0;
        a_d     = grant[1] ? a1 : a0;
        b_d     = grant[1] ? b1 : b0;
        c_d     = grant[1] ? c1 : c0;
        err_d   = 1'b0;
        state_d = START;
      end
      START:  state_d = LOAD_A;
      LOAD_A: state_d = LOAD_B;
      LOAD_B: begin
        cnt_d   = '0;
        state_d = op_q == OP_DIV ? LOAD_C : WAIT;
      end
      LOAD_C: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      // op_q[1] marks mul/div, which return a second byte
      WAIT: if (alu.alu_end) begin
        res_nxt = {op_q[1] ? res_cur[15:8] : 8'h00, alu.alu_out};
        state_d = op_q[1] ? RES_HI : DONE;
      end else if (timeout) begin
        res_nxt = 16'hFFFF;
        err_d   = 1'b1;
        state_d = DONE;
      end else begin
        cnt_d = cnt_q + TW'(1);
      end
      RES_HI: begin
        res_nxt = {alu.alu_out, res_cur[7:0]};
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    if (side_q) res1_d = res_nxt;
    else res0_d = res_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      side_q  <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      res0_q  <= '0;
      res1_q  <= '0;
    end else begin
      state_q <= state_d;
      side_q  <= side_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      res0_q  <= res0_d;
      res1_q  <= res1_d;
    end
  end

  always_comb begin
    busy          = state_q != IDLE;
    alu.alu_begin = state_q == START;
    alu.alu_op    = busy ? op_q : 2'b00;
    alu.alu_in    = state_q == LOAD_A ? a_q : state_q == LOAD_B ? b_q : state_q == LOAD_C ? c_q : 8'h00;
    done0         = state_q == DONE && !side_q;
    done1         = state_q == DONE && side_q;
    err0          = done0 && err_q;
    err1          = done1 && err_q;
    res0          = res0_q;
    res1          = res1_q;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, max cycles from last operand load to alu_end before abort.
REQ-002 SHALL have parameter TW, default 7, width of the timeout counter.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports req0/req1  input  1  job request, held high until matching done pulse.
REQ-006 SHALL have ports op0/op1  input  2  opcode: 00 add, 01 sub, 10 mul, 11 div.
REQ-007 SHALL have ports a0,b0,c0 / a1,b1,c1  input  8 each  operands; c used by div only.
REQ-008 SHALL have ports done0/done1  output  1  one-cycle completion pulse.
REQ-009 SHALL have ports res0/res1  output  16  result, valid while done high and held until next job for that requester.
REQ-010 SHALL have ports err0/err1  output  1  high with done when the job timed out.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have ports alu_op  output  2; alu_in  output  8; alu_begin  output  1  drive the shared ALU.
REQ-013 SHALL have ports alu_out  input  8; alu_end  input  1  ALU result byte and end pulse.

Function
REQ-014 FSM states SHALL be IDLE, START, LOAD_A, LOAD_B, LOAD_C, WAIT, RES_HI, DONE.
REQ-015 IDLE: on any req high SHALL grant, latch op/a/b/c of granted side, go START next cycle.
REQ-016 Both req high in IDLE SHALL grant the side not served last (round-robin; after reset side 0 wins).
REQ-017 START: alu_begin=1 for exactly one cycle, alu_op=latched op; SHALL go LOAD_A.
REQ-018 LOAD_A: alu_in=a; LOAD_B: alu_in=b; LOAD_C (div only): alu_in=c; alu_begin=0 throughout.
REQ-019 After LOAD_B (add/sub/mul) or LOAD_C (div) SHALL enter WAIT and clear timeout counter.
REQ-020 alu_op SHALL stay at latched op from START through DONE; alu_in SHALL be 0 outside load states.
REQ-021 WAIT: alu_end high SHALL capture alu_out into res[7:0]; add/sub set res[15:8]=0 and go DONE; mul/div go RES_HI.
REQ-022 RES_HI: SHALL capture alu_out into res[15:8] (mul high byte / div remainder), go DONE.
REQ-023 WAIT: counter reaching TIMEOUT without alu_end SHALL set err, res=16'hFFFF, go DONE.
REQ-024 DONE: done/err of granted side high one cycle, other side's outputs unchanged; SHALL go IDLE.
REQ-025 Latency: done SHALL rise 1 cycle after alu_end (add/sub), 2 cycles (mul/div).
REQ-026 req changes after grant SHALL be ignored until DONE; req still high in IDLE after DONE is a new job.
REQ-027 alu_end outside WAIT SHALL be ignored.

Reset
REQ-028 rst low SHALL immediately force IDLE, all outputs 0, res0/res1 0, round-robin pointer to side 0.
REQ-029 Reset mid-job SHALL abort with no done pulse; ALU is reset by the same rst.

Structure
REQ-030 Package alu_pkg SHALL hold opcode constants OP_ADD/OP_SUB/OP_MUL/OP_DIV and the FSM state encoding.
REQ-031 Two-way round-robin grant SHALL be a sub-module rr_arb2 (req[1:0], advance -> grant[1:0]).

Verification
REQ-032 req0 add a=0x02 b=0x03 -> alu_in 0x02 then 0x03, done0 with res0=0x0005, err0=0.
REQ-033 req1 sub a=0x07 b=0x02 -> res1=0x0005; mul a=0xC5 b=0x04 -> res=0x0314, done 2 cycles after alu_end.
REQ-034 req0 div a=0x31 b=0x12 c=0x7B -> three load cycles, res0=0x1066 (rem 0x10, quot 0x66).
REQ-035 req0 and req1 raised same cycle, both held -> side 0 served, then side 1, then side 0; no starvation.
REQ-036 ALU model withholds alu_end -> done with err=1, res=0xFFFF exactly TIMEOUT cycles after WAIT entry.
REQ-037 rst low during LOAD_B -> busy=0, alu_begin=0 same cycle; no done; next req completes normally.
